// File: rtl/keycode_move_ctrl.sv
// Turns the level-valued HID keycode into discrete move/fire commands with typematic repeat.
// Optional input stability filter is enabled by defining KEYCODE_FILTER_EN.
module keycode_move_ctrl #(
  parameter int unsigned REPEAT_DELAY  = 32'd12_500_000,
  parameter int unsigned REPEAT_PERIOD = 32'd2_500_000,
  parameter int unsigned FILTER_CYCLES = 4
) (
  input  logic       clk_clk,
  input  logic       reset_reset_n,
  input  logic [7:0] keycode,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd,
  output logic       key_held,
  output logic [7:0] drop_cnt
);

  localparam int unsigned MaxCnt = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned CntW   = $clog2(MaxCnt);
  localparam logic [CntW-1:0] DelayLoad  = CntW'(REPEAT_DELAY - 1);
  localparam logic [CntW-1:0] PeriodLoad = CntW'(REPEAT_PERIOD - 1);

  if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2 || FILTER_CYCLES < 1) begin : g_param_check
    $error("keycode_move_ctrl: parameter out of range");
  end

  typedef enum logic [1:0] {StIdle, StDelay, StRepeat} state_e;

  logic [7:0] acc_key;

`ifdef KEYCODE_FILTER_EN
  localparam int unsigned StabW = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [StabW-1:0] StabMax = StabW'(FILTER_CYCLES - 1);

  logic [7:0]       raw_q, filt_q;
  logic [StabW-1:0] stab_q, stab_d;

  // stab_d is the zero-based length of the current run of identical raw samples.
  always_comb begin
    stab_d = '0;
    if (keycode == raw_q) begin
      stab_d = (stab_q == StabMax) ? stab_q : stab_q + 1'b1;
    end
    acc_key = (stab_d == StabMax) ? keycode : filt_q;
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      raw_q  <= 8'h00;
      stab_q <= '0;
      filt_q <= 8'h00;
    end else begin
      raw_q  <= keycode;
      stab_q <= stab_d;
      filt_q <= acc_key;
    end
  end
`else
  assign acc_key = keycode;
`endif

  logic       mapped;
  logic [2:0] map_cmd;

  always_comb begin
    mapped  = 1'b1;
    map_cmd = 3'd0;
    unique case (acc_key)
      8'h1A:   map_cmd = 3'd0;
      8'h16:   map_cmd = 3'd1;
      8'h04:   map_cmd = 3'd2;
      8'h07:   map_cmd = 3'd3;
      8'h2C:   map_cmd = 3'd4;
      default: mapped  = 1'b0;
    endcase
  end

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      key_q;
  logic            valid_q, valid_d;
  logic [2:0]      cmd_q, cmd_d;
  logic            held_q, held_d;
  logic [7:0]      drop_q, drop_d;
  logic            fire;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    fire    = 1'b0;
    if (acc_key != key_q) begin
      if (mapped) begin
        fire    = 1'b1;
        cnt_d   = DelayLoad;
        state_d = StDelay;
      end else begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    end else if (state_q != StIdle) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else begin
        fire    = 1'b1;
        cnt_d   = PeriodLoad;
        state_d = StRepeat;
      end
    end
    held_d = (state_d != StIdle);

    valid_d = valid_q;
    cmd_d   = cmd_q;
    drop_d  = drop_q;
    if (fire) begin
      valid_d = 1'b1;
      cmd_d   = map_cmd;
      // An unaccepted command is being replaced by a newer one.
      if (valid_q && !cmd_ready && drop_q != 8'hFF) begin
        drop_d = drop_q + 8'd1;
      end
    end else if (valid_q && cmd_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      key_q   <= 8'h00;
      valid_q <= 1'b0;
      cmd_q   <= 3'd0;
      held_q  <= 1'b0;
      drop_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      key_q   <= acc_key;
      valid_q <= valid_d;
      cmd_q   <= cmd_d;
      held_q  <= held_d;
      drop_q  <= drop_d;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd       = cmd_q;
  assign key_held  = held_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_keycode_move_ctrl.sv
// Bench for keycode_move_ctrl: vector table, directed corner sequences, random vs. reference model.
module tb_keycode_move_ctrl;

  localparam int D = 8;
  localparam int P = 4;
  localparam int F = 3;
`ifdef KEYCODE_FILTER_EN
  localparam int Lat = F - 1;
`else
  localparam int Lat = 0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rdy = 1'b1;
  logic [7:0] kc = 8'h00;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic       key_held;
  logic [7:0] drop_cnt;

  always #5 clk = ~clk;

  keycode_move_ctrl #(
    .REPEAT_DELAY (D),
    .REPEAT_PERIOD(P),
    .FILTER_CYCLES(F)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .keycode      (kc),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (rdy),
    .cmd          (cmd),
    .key_held     (key_held),
    .drop_cnt     (drop_cnt)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: hold age since the press decides repeats; history queue decides filtering.
  logic [7:0] m_acc, m_prev;
  int         m_age;
  logic       m_valid, m_held;
  logic [2:0] m_cmd;
  int         m_drop;
  logic [7:0] hist[$];

  function automatic int map_of(input logic [7:0] k);
    case (k)
      8'h1A:   return 0;
      8'h16:   return 1;
      8'h04:   return 2;
      8'h07:   return 3;
      8'h2C:   return 4;
      default: return -1;
    endcase
  endfunction

  task automatic model_step();
    bit ev;
    bit all_eq;
    if (!rst_n) begin
      m_acc = 8'h00; m_prev = 8'h00; m_age = -1;
      m_valid = 1'b0; m_held = 1'b0; m_cmd = 3'd0; m_drop = 0;
      hist.delete();
      return;
    end
`ifdef KEYCODE_FILTER_EN
    hist.push_back(kc);
    if (hist.size() > F) void'(hist.pop_front());
    all_eq = (hist.size() == F);
    foreach (hist[i]) if (hist[i] != kc) all_eq = 1'b0;
    if (all_eq) m_acc = kc;
`else
    all_eq = 1'b1;
    m_acc = kc;
`endif
    ev = 1'b0;
    if (m_acc != m_prev) begin
      if (map_of(m_acc) >= 0) begin
        m_age = 0; ev = 1'b1; m_held = 1'b1;
      end else begin
        m_age = -1; m_held = 1'b0;
      end
    end else if (m_age >= 0) begin
      m_age++;
      if (m_age >= D && ((m_age - D) % P) == 0) ev = 1'b1;
    end
    m_prev = m_acc;
    if (ev) begin
      if (m_valid && !rdy && m_drop < 255) m_drop++;
      m_valid = 1'b1;
      m_cmd = 3'(map_of(m_acc));
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    check("model_valid", 32'(cmd_valid), 32'(m_valid));
    check("model_cmd", 32'(cmd), 32'(m_cmd));
    check("model_held", 32'(key_held), 32'(m_held));
    check("model_drop", 32'(drop_cnt), 32'(m_drop));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst_n;
    logic [7:0] kc;
    logic       rdy;
    logic       v;
    logic [2:0] c;
    logic       h;
    logic [7:0] d;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [7:0] k, input logic y, input logic v,
                     input logic [2:0] c, input logic h, input logic [7:0] d);
    vec_t t;
    t.rst_n = r; t.kc = k; t.rdy = y; t.v = v; t.c = c; t.h = h; t.d = d;
    tbl.push_back(t);
  endtask

  initial begin
    int segs;
    bit exp_pulse;

    // Vector table: {rst_n, keycode, ready} -> {valid, cmd, held, drop} after the edge.
`ifdef KEYCODE_FILTER_EN
    add(1, 8'h16, 1, 0, 0, 0, 0);
    add(1, 8'h16, 1, 0, 0, 0, 0);
    add(1, 8'h16, 1, 1, 1, 1, 0);
    add(1, 8'h16, 1, 0, 1, 1, 0);
    add(1, 8'h00, 1, 0, 1, 1, 0);
    add(1, 8'h00, 1, 0, 1, 1, 0);
    add(1, 8'h00, 1, 0, 1, 0, 0);
    add(1, 8'h04, 1, 0, 1, 0, 0);
    add(1, 8'h16, 1, 0, 1, 0, 0);
    add(1, 8'h16, 1, 0, 1, 0, 0);
    add(1, 8'h00, 1, 0, 1, 0, 0);
    add(1, 8'h2C, 0, 0, 1, 0, 0);
    add(1, 8'h2C, 0, 0, 1, 0, 0);
    add(1, 8'h2C, 0, 1, 4, 1, 0);
    add(1, 8'h1A, 0, 1, 4, 1, 0);
    add(1, 8'h1A, 0, 1, 4, 1, 0);
    add(1, 8'h1A, 0, 1, 0, 1, 1);
    add(0, 8'h00, 1, 0, 0, 0, 0);
`else
    add(1, 8'h04, 1, 1, 2, 1, 0);
    add(1, 8'h04, 1, 0, 2, 1, 0);
    add(1, 8'h04, 1, 0, 2, 1, 0);
    add(1, 8'h07, 1, 1, 3, 1, 0);
    for (int i = 0; i < 7; i++) add(1, 8'h07, 1, 0, 3, 1, 0);
    add(1, 8'h07, 0, 1, 3, 1, 0);
    add(1, 8'h07, 0, 1, 3, 1, 0);
    add(1, 8'h07, 1, 0, 3, 1, 0);
    add(1, 8'h07, 0, 0, 3, 1, 0);
    add(1, 8'h07, 0, 1, 3, 1, 0);
    for (int i = 0; i < 3; i++) add(1, 8'h07, 0, 1, 3, 1, 0);
    add(1, 8'h1A, 1, 1, 0, 1, 0);
    add(1, 8'h1A, 0, 1, 0, 1, 0);
    add(1, 8'h05, 0, 1, 0, 0, 0);
    add(1, 8'h05, 1, 0, 0, 0, 0);
    add(1, 8'h00, 1, 0, 0, 0, 0);
    add(1, 8'h2C, 0, 1, 4, 1, 0);
    add(1, 8'h1A, 0, 1, 0, 1, 1);
    add(1, 8'h00, 1, 0, 0, 0, 1);
    add(0, 8'h00, 1, 0, 0, 0, 0);
`endif

    rst_n = 1'b0; kc = 8'h00; rdy = 1'b1;
    tick();
    tick();
    check("reset_valid", 32'(cmd_valid), 32'd0);
    check("reset_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    foreach (tbl[i]) begin
      rst_n = tbl[i].rst_n; kc = tbl[i].kc; rdy = tbl[i].rdy;
      tick();
      check($sformatf("tbl%0d_valid", i), 32'(cmd_valid), 32'(tbl[i].v));
      check($sformatf("tbl%0d_cmd", i), 32'(cmd), 32'(tbl[i].c));
      check($sformatf("tbl%0d_held", i), 32'(key_held), 32'(tbl[i].h));
      check($sformatf("tbl%0d_drop", i), 32'(drop_cnt), 32'(tbl[i].d));
    end
    rst_n = 1'b1; kc = 8'h00; rdy = 1'b1;
    for (int i = 0; i < 4; i++) tick();

    // Typematic timing: pulses exactly at press, +D, +D+P, +D+2P.
    kc = 8'h1A;
    for (int e = 0; e <= Lat + 17; e++) begin
      tick();
      exp_pulse = (e == Lat) || (e == Lat + D) || (e == Lat + D + P) || (e == Lat + D + 2 * P);
      check($sformatf("rep_pulse_e%0d", e), 32'(cmd_valid), 32'(exp_pulse));
    end
    check("rep_held", 32'(key_held), 32'd1);
    kc = 8'h00;
    for (int e = 0; e <= Lat; e++) tick();
    check("rel_held", 32'(key_held), 32'd0);
    for (int e = 0; e < 2 * D; e++) begin
      tick();
      check("rel_no_pulse", 32'(cmd_valid), 32'd0);
    end

    // Saturating overwrite count with the consumer stalled.
    rdy = 1'b0;
    for (int n = 0; n < 300; n++) begin
      kc = n[0] ? 8'h07 : 8'h04;
      for (int j = 0; j <= Lat; j++) tick();
    end
    check("sat_drop", 32'(drop_cnt), 32'd255);
    check("sat_valid", 32'(cmd_valid), 32'd1);
    rdy = 1'b1;
    tick();
    check("sat_accept_valid", 32'(cmd_valid), 32'd0);
    check("sat_drop_hold", 32'(drop_cnt), 32'd255);
    kc = 8'h00;
    for (int j = 0; j < 4; j++) tick();

    // Reset mid-REPEAT with a pending command; an off-edge low pulse must be ignored.
    rdy = 1'b0; kc = 8'h2C;
    for (int j = 0; j < Lat + D + P + 2; j++) tick();
    check("pend_valid", 32'(cmd_valid), 32'd1);
    check("pend_cmd", 32'(cmd), 32'd4);
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    tick();
    check("async_pulse_valid", 32'(cmd_valid), 32'd1);
    check("async_pulse_held", 32'(key_held), 32'd1);
    rst_n = 1'b0;
    tick();
    check("rst_valid", 32'(cmd_valid), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst_n = 1'b1;
    for (int j = 0; j <= Lat; j++) tick();
    check("post_rst_fire", 32'(cmd_valid), 32'd1);

    // Random phase against the reference model.
    segs = 0;
    while (segs < 400) begin
      int hold;
      int pick;
      pick = int'($urandom_range(0, 7));
      case (pick)
        0: kc = 8'h1A;
        1: kc = 8'h16;
        2: kc = 8'h04;
        3: kc = 8'h07;
        4: kc = 8'h2C;
        5: kc = 8'h05;
        default: kc = 8'h00;
      endcase
      hold = int'($urandom_range(1, 16));
      for (int j = 0; j < hold; j++) begin
        rdy = ($urandom_range(0, 3) != 0);
        rst_n = ($urandom_range(0, 299) != 0);
        tick();
      end
      rst_n = 1'b1;
      segs++;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
